instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_if.sv | 25 ++
 rtl/instr_loader.sv | 154 +++++++++++++++
 tb/tb_instr_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write bus for instr_loader.
// slave is the loader side; master is the byte source / memory side.
interface instr_loader_if #(
  parameter int NADDRE = 8,
  parameter int NBDATA = 12
);
  localparam int AW = (NADDRE > 1) ? $clog2(NADDRE) : 1;

  logic [7:0]        rx_data;
  logic              rx_vld;
  logic              rx_rdy;
  logic              mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [NBDATA-1:0] mem_data;

  modport slave (
    input  rx_data, rx_vld,
    output rx_rdy, mem_wr, mem_addr, mem_data
  );

  modport master (
    output rx_data, rx_vld,
    input  rx_rdy, mem_wr, mem_addr, mem_data
  );
endinterface

// File: rtl/instr_loader.sv
// Loads instruction memory from a framed byte stream:
// A5, 16-bit word count, N words of NB bytes (MSB first), XOR checksum.
module instr_loader #(
  parameter int NADDRE = 8,
  parameter int NBDATA = 12
) (
  input  logic            clk,
  input  logic            rst,
  instr_loader_if.slave   bus,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int NB  = (NBDATA + 7) / 8;
  localparam int AW  = (NADDRE > 1) ? $clog2(NADDRE) : 1;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    IDLE, LEN_H, LEN_L, DATA, CSUM, WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [BIW-1:0]    bidx_q, bidx_d;
  logic [NB*8-1:0]   shreg_q, shreg_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [NBDATA-1:0] data_q, data_d;
  logic [7:0]        csum_q, csum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              acc;

  assign bus.rx_rdy   = (state_q != WRITE);
  assign bus.mem_wr   = (state_q == WRITE);
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign acc          = bus.rx_vld && (state_q != WRITE);

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    bidx_d   = bidx_q;
    shreg_d  = shreg_q;
    addr_d   = addr_q;
    data_d   = data_q;
    csum_d   = csum_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (acc && bus.rx_data == 8'hA5) begin
          state_d = LEN_H;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          csum_d  = '0;
          addr_d  = '0;
          wcnt_d  = '0;
          bidx_d  = '0;
        end
      end
      LEN_H: begin
        if (acc) begin
          len_hi_d = bus.rx_data;
          state_d  = LEN_L;
        end
      end
      LEN_L: begin
        if (acc) begin
          cnt_d = {len_hi_q, bus.rx_data};
          if (cnt_d == 16'd0 || cnt_d > 16'(NADDRE)) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (acc) begin
          shreg_d      = shreg_q << 8;
          shreg_d[7:0] = bus.rx_data;
          csum_d       = csum_q ^ bus.rx_data;
          if (bidx_q == BIW'(NB - 1)) begin
            bidx_d  = '0;
            data_d  = shreg_d[NBDATA-1:0];
            state_d = WRITE;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      WRITE: begin
        // address only advances when another word follows, so it never wraps
        wcnt_d = wcnt_q + 16'd1;
        if (wcnt_d == cnt_q) begin
          state_d = CSUM;
        end else begin
          state_d = DATA;
          addr_d  = addr_q + 1'b1;
        end
      end
      CSUM: begin
        if (acc) begin
          if (bus.rx_data == csum_q) done_d = 1'b1;
          else                       err_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_hi_q <= '0;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      bidx_q   <= '0;
      shreg_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      csum_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      bidx_q   <= bidx_d;
      shreg_q  <= shreg_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      csum_q   <= csum_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares on every mem_wr.
module tb_instr_loader;
  localparam int NADDRE = 8;
  localparam int NBDATA = 12;

  logic clk = 1'b0;
  logic rst;
  logic busy, done, err;

  instr_loader_if #(.NADDRE(NADDRE), .NBDATA(NBDATA)) bus ();

  instr_loader #(.NADDRE(NADDRE), .NBDATA(NBDATA)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q [$];
  logic [15:0] wbuf [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_wr) begin
        check("rx_rdy_in_write", 32'(bus.rx_rdy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   bus.mem_addr, bus.mem_data);
        end else begin
          logic [14:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(e[14:12]));
          check("wr_data", 32'(bus.mem_data), 32'(e[11:0]));
        end
      end else if (!bus.rx_rdy) begin
        check("rx_rdy_outside_write", 32'(bus.rx_rdy), 32'd1);
      end
    end
  end

  // Present a byte and hold it until it is accepted; rx_vld stays high.
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    bus.rx_data = b;
    bus.rx_vld  = 1'b1;
    while (!bus.rx_rdy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) check("send_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.rx_vld = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input int n, input bit bad);
    logic [7:0] cs;
    logic [15:0] nn;
    cs = 8'h00;
    nn = 16'(n);
    send(8'hA5);
    send(nn[15:8]);
    send(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({3'(i), wbuf[i][11:0]});
      send(wbuf[i][15:8]);
      send(wbuf[i][7:0]);
      cs = cs ^ wbuf[i][15:8] ^ wbuf[i][7:0];
    end
    send(bad ? 8'h00 : cs);
    idle(3);
  endtask

  task automatic status(input string tag, input logic b, input logic d, input logic e);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"},  32'(err),  32'(e));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_vld  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_wr",   32'(bus.mem_wr),   32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_data", 32'(bus.mem_data), 32'd0);
    check("rst_rx_rdy",   32'(bus.rx_rdy),   32'd1);
    status("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(2);

    // Good load: A5 00 02 01 23 0F FF D2, fed with rx_vld held high.
    wbuf[0] = 16'h0123;
    wbuf[1] = 16'h0FFF;
    frame(2, 1'b0);
    status("good", 1'b0, 1'b1, 1'b0);

    // Same frame with checksum byte 00.
    frame(2, 1'b1);
    status("badcs", 1'b0, 1'b0, 1'b1);

    // N too large and N zero: no writes.
    send(8'hA5);
    check("busy_after_sync", 32'(busy), 32'd1);
    send(8'h00); send(8'h09); idle(3);
    status("n9", 1'b0, 1'b0, 1'b1);
    send(8'hA5); send(8'h00); send(8'h00); idle(3);
    status("n0", 1'b0, 1'b0, 1'b1);

    // Full memory; A5 bytes inside data, unused high nibble ignored.
    wbuf[0] = 16'hA5A5; wbuf[1] = 16'h0001; wbuf[2] = 16'h0F00; wbuf[3] = 16'h00A5;
    wbuf[4] = 16'h3123; wbuf[5] = 16'h0456; wbuf[6] = 16'hF789; wbuf[7] = 16'h0FFF;
    frame(8, 1'b0);
    status("n8", 1'b0, 1'b1, 1'b0);

    // Junk before sync.
    wbuf[0] = 16'h0123;
    wbuf[1] = 16'h0FFF;
    send(8'h00); send(8'hFF);
    frame(2, 1'b0);
    status("junk", 1'b0, 1'b1, 1'b0);

    // Reset after the first word is written.
    send(8'hA5); send(8'h00); send(8'h02);
    exp_q.push_back({3'd0, 12'h123});
    send(8'h01); send(8'h23);
    idle(2);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("midrst_addr",   32'(bus.mem_addr), 32'd0);
    send(8'h0F); send(8'hFF);
    idle(4);
    status("midrst", 1'b0, 1'b0, 1'b0);
    frame(2, 1'b0);
    status("restart", 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
